shift_sequence_controller: RTL

SHIFT_SEQUENCE_CONTROLLER -- requirements
Module: shift_sequence_controller

---
 rtl/shift_sequence_controller.sv | 93 +++++++++
 1 files changed

// File: rtl/shift_sequence_controller.sv
// Loadable shift register stepped one bit per clock under a three-state sequencer.
// Supports left, logical-right and arithmetic-right shifts, with abort and a one-cycle done pulse.
module shift_sequence_controller #(
   parameter int WIDTH = 128,
   parameter int CNT_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] D,
   input  logic [CNT_W-1:0] amount,
   input  logic             dir,
   input  logic             arith,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Q,
   output logic [CNT_W-1:0] count
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic             dir_q, dir_d;
   logic             arith_q, arith_d;
   logic [WIDTH-1:0] q_d;
   logic [CNT_W-1:0] count_d;
   logic             fill;

   // Only arithmetic right shifts replicate the sign bit.
   assign fill = arith_q & Q[WIDTH-1];

   always_comb begin
      state_d = state_q;
      q_d     = Q;
      count_d = count;
      dir_d   = dir_q;
      arith_d = arith_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               q_d     = D;
               count_d = amount;
               dir_d   = dir;
               arith_d = arith;
               state_d = (amount == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            if (abort) begin
               state_d = IDLE;
               count_d = '0;
            end else begin
               q_d     = dir_q ? {fill, Q[WIDTH-1:1]} : {Q[WIDTH-2:0], 1'b0};
               count_d = count - CNT_W'(1);
               if (count == CNT_W'(1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         dir_q   <= 1'b0;
         arith_q <= 1'b0;
         Q       <= '0;
         count   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         arith_q <= arith_d;
         Q       <= q_d;
         count   <= count_d;
         // Flags come from the next state so they line up with the state register.
         busy    <= (state_d == SHIFT);
         done    <= (state_d == DONE);
      end
   end

endmodule
